pipe_mux_tree: RTL and testbench

Pipelined, parametrised 2^N-to-1 selector with valid/ready flow control: it picks one W-bit channel out of 2^N by a binary select and also emits the one-hot decode of that select. It is the registered, multi-bit successor to the single-bit combinational mux tree and decoder used in the auction datapath. It sits between bid storage and the comparison/winner logic, so a bid can be fetched every cycle at a fixed clock rate regardless of bidder count.

---
 rtl/mux_tree_stage.sv | 47 ++++
 rtl/pipe_mux_tree.sv | 97 +++++++++
 tb/tb_pipe_mux_tree.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_tree_stage.sv
// One level of the registered select tree: a row of 2:1 muxes feeding a
// data register, plus the valid/select registers and the local advance rule.
module mux_tree_stage #(
   parameter int WIDTH = 32,
   parameter int WORDS = 1,
   parameter int N     = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           up_valid,
   input  logic [2*WORDS-1:0][WIDTH-1:0]  up_data,
   input  logic [N-1:0]                   up_sel,
   input  logic                           pick,
   input  logic                           down_ready,
   output logic                           load,
   output logic                           valid,
   output logic [WORDS-1:0][WIDTH-1:0]    data,
   output logic [N-1:0]                   sel
);

   logic [WORDS-1:0][WIDTH-1:0] mux_row;

   always_comb begin
      mux_row = '0;
      for (int k = 0; k < WORDS; k++)
         mux_row[k] = pick ? up_data[2*k+1] : up_data[2*k];
   end

   // Advance when empty or when whatever sits downstream is taking our word.
   assign load = !valid || down_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         sel   <= '0;
      end else if (load) begin
         valid <= up_valid;
         // A bubble moving in leaves the previous word untouched.
         if (up_valid) begin
            data <= mux_row;
            sel  <= up_sel;
         end
      end
   end

endmodule

// File: rtl/pipe_mux_tree.sv
// Pipelined 2^N-to-1 channel selector with valid/ready flow control and a
// registered one-hot decode of the select that produced each output word.
module pipe_mux_tree #(
   parameter int N = 3,
   parameter int W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W*(2**N)-1:0]  in_data,
   input  logic [N-1:0]         in_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data,
   output logic [N-1:0]         out_sel,
   output logic [(2**N)-1:0]    out_onehot
);

   localparam int CH = 2**N;

   logic          first_load;
   logic          last_load;
   logic          last_up_valid;
   logic [N-1:0]  last_up_sel;
   logic [CH-1:0] onehot_nxt;

   for (genvar j = 0; j < N; j++) begin : lvl
      localparam int WORDS = 2**(N-1-j);

      logic                        up_valid;
      logic [2*WORDS-1:0][W-1:0]   up_data;
      logic [N-1:0]                up_sel;
      logic                        down_ready;
      logic                        load;
      logic                        valid;
      logic [WORDS-1:0][W-1:0]     data;
      logic [N-1:0]                sel;

      if (j == 0) begin : g_head
         assign up_valid   = in_valid;
         assign up_data    = in_data;
         assign up_sel     = in_sel;
         assign first_load = load;
      end else begin : g_body
         assign up_valid = lvl[j-1].valid;
         assign up_data  = lvl[j-1].data;
         assign up_sel   = lvl[j-1].sel;
      end

      if (j == N-1) begin : g_tail
         assign down_ready    = out_ready;
         assign last_load     = load;
         assign last_up_valid = up_valid;
         assign last_up_sel   = up_sel;
         assign out_valid     = valid;
         assign out_data      = data[0];
         assign out_sel       = sel;
      end else begin : g_link
         assign down_ready = lvl[j+1].load;
      end

      mux_tree_stage #(
         .WIDTH (W),
         .WORDS (WORDS),
         .N     (N)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .up_valid   (up_valid),
         .up_data    (up_data),
         .up_sel     (up_sel),
         .pick       (up_sel[j]),
         .down_ready (down_ready),
         .load       (load),
         .valid      (valid),
         .data       (data),
         .sel        (sel)
      );
   end

   assign in_ready = !rst && first_load;

   always_comb begin
      onehot_nxt              = '0;
      onehot_nxt[last_up_sel] = 1'b1;
   end

   // Decoded alongside the last stage so it always matches out_sel.
   always_ff @(posedge clk) begin
      if (rst)
         out_onehot <= '0;
      else if (last_load && last_up_valid)
         out_onehot <= onehot_nxt;
   end

endmodule

// File: tb/tb_pipe_mux_tree.sv
// Directed plus randomized bench for pipe_mux_tree (N=3, W=8) against a
// queue-based model of accepted beats.
module tb_pipe_mux_tree;
   localparam int N  = 3;
   localparam int W  = 8;
   localparam int CH = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [W*CH-1:0]   in_data;
   logic [N-1:0]      in_sel;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic [N-1:0]      out_sel;
   logic [CH-1:0]     out_onehot;

   always #5 clk = ~clk;

   pipe_mux_tree #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sel    (out_sel),
      .out_onehot (out_onehot)
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic [N-1:0] s;
   } beat_t;

   beat_t        q[$];
   logic [W-1:0] chv [CH];
   int tests = 0, fails = 0;
   int cyc_no = 0, pops = 0, gaps = 0, prev_pop = -1, accepts = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_ch();
      for (int k = 0; k < CH; k++) in_data[k*W +: W] = chv[k];
   endtask

   // Evaluate handshakes for the current cycle, then advance one clock.
   task automatic cyc();
      #1;
      if (out_valid) begin
         if (q.size() == 0) chk("spurious_out", out_valid, 0);
         else begin
            chk("out_data", out_data, q[0].d);
            chk("out_sel", out_sel, q[0].s);
            chk("out_onehot", out_onehot, 64'd1 << q[0].s);
            if (out_ready) begin
               void'(q.pop_front());
               if (prev_pop >= 0 && cyc_no != prev_pop + 1) gaps++;
               prev_pop = cyc_no;
               pops++;
            end
         end
      end
      if (!rst && in_valid && in_ready) begin
         q.push_back('{d: chv[in_sel], s: in_sel});
         accepts++;
      end
      @(posedge clk);
      cyc_no++;
      #1;
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while (q.size() != 0 && n < bound) begin
         cyc();
         n++;
      end
      chk("drain_done", q.size(), 0);
   endtask

   initial begin
      int n;
      int seen;
      logic [W-1:0]  hd;
      logic [N-1:0]  hs;
      logic [CH-1:0] ho;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sel = '0;
      for (int k = 0; k < CH; k++) chv[k] = '0;
      drive_ch();

      // Reset held two cycles
      for (int r = 0; r < 2; r++) begin
         @(posedge clk); #1;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_out_onehot", out_onehot, 0);
         chk("rst_in_ready", in_ready, 0);
      end
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Single beat, latency
      for (int k = 0; k < CH; k++) chv[k] = 8'h10 + 8'(k);
      drive_ch();
      in_sel = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
         cyc();
         n++;
      end
      chk("latency", n, N);
      chk("single_data", out_data, 8'h15);
      chk("single_sel", out_sel, 3'd5);
      chk("single_onehot", out_onehot, 8'b0010_0000);
      drain(10);

      // Streaming at full rate
      pops = 0; gaps = 0; prev_pop = -1;
      for (int i = 0; i < CH; i++) begin
         in_sel = 3'(i); in_valid = 1'b1;
         chk("stream_in_ready", in_ready, 1);
         cyc();
      end
      in_valid = 1'b0;
      drain(20);
      chk("stream_pops", pops, 8);
      chk("stream_gaps", gaps, 0);

      // Backpressure: pipe buffers exactly N beats
      out_ready = 1'b0; pops = 0; accepts = 0; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_sel = 3'(accepts);
         cyc();
      end
      chk("bp_accepted", accepts, 3);
      chk("bp_in_ready", in_ready, 0);
      hd = out_data; hs = out_sel; ho = out_onehot;
      cyc(); cyc();
      chk("bp_hold_data", out_data, hd);
      chk("bp_hold_sel", out_sel, hs);
      chk("bp_hold_onehot", out_onehot, ho);
      chk("bp_hold_valid", out_valid, 1);
      out_ready = 1'b1;
      n = 0;
      while (accepts < 6 && n < 20) begin
         in_sel = 3'(accepts);
         cyc();
         n++;
      end
      in_valid = 1'b0;
      drain(20);
      chk("bp_pops", pops, 6);

      // Random bubbles and backpressure
      accepts = 0; n = 0;
      while (accepts < 1000 && n < 8000) begin
         for (int k = 0; k < CH; k++) chv[k] = 8'($urandom);
         drive_ch();
         in_sel    = 3'($urandom);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
         n++;
      end
      chk("rand_accepted", accepts, 1000);
      in_valid = 1'b0; out_ready = 1'b1;
      drain(50);

      // Reset with three beats in flight
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_sel = 3'($urandom);
         cyc();
      end
      chk("mid_full", q.size(), 3);
      in_valid = 1'b0; rst = 1'b1;
      q.delete();
      @(posedge clk); #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_onehot", out_onehot, 0);
      rst = 1'b0; out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) seen++;
         cyc();
      end
      chk("mid_no_ghost", seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
